// File: rtl/lcd_char_fifo.sv
// Circular character FIFO between the CPU LCD write strobe and the LCD controller handshake.
// Optional sticky overflow flag enabled by defining LCD_FIFO_OVF_STICKY_EN.
module lcd_char_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 3,
    parameter int BUSY_WAIT  = 15
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iWrite,
    input  logic [DATA_W-1:0]     iData,
    output logic                  oReady,
    output logic                  oFull,
    output logic                  oEmpty,
    output logic [DEPTH_LOG2:0]   oCount,
    output logic                  oLcdWrite,
    output logic [DATA_W-1:0]     oLcdData,
    input  logic                  iLcdReady,
    output logic                  oOverflow,
    input  logic                  iClearOvf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TMO_W = $clog2(BUSY_WAIT + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_LO = 2'd2;
    localparam logic [1:0] ST_WAIT_HI = 2'd3;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic [1:0]            r_state;
    logic [TMO_W-1:0]      r_tmo;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_tmo_done;
    logic [DEPTH_LOG2:0]   w_count_nxt;
    logic [1:0]            w_state_nxt;

    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign w_push     = iWrite && !r_full;
    assign w_pop      = (r_state == ST_ISSUE) && iLcdReady;
    assign w_tmo_done = (r_tmo == TMO_W'(BUSY_WAIT - 1));

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= iData;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (DEPTH_LOG2 + 1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!r_empty && iLcdReady) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (iLcdReady) begin
                    w_state_nxt = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                // A controller that never signals busy must not hang the drain.
                if (!iLcdReady) begin
                    w_state_nxt = ST_WAIT_HI;
                end else if (w_tmo_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                if (iLcdReady) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state != ST_WAIT_LO) begin
                r_tmo <= '0;
            end else if (!w_tmo_done) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

`ifdef LCD_FIFO_OVF_STICKY_EN
    logic r_ovf;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_ovf <= 1'b0;
        end else if (iWrite && r_full) begin
            r_ovf <= 1'b1;
        end else if (iClearOvf) begin
            r_ovf <= 1'b0;
        end
    end

    assign oOverflow = r_ovf;
`else
    logic w_unused_clr;

    assign w_unused_clr = iClearOvf;
    assign oOverflow    = 1'b0;
`endif

    assign oReady    = !r_full;
    assign oFull     = r_full;
    assign oEmpty    = r_empty;
    assign oCount    = r_count;
    assign oLcdWrite = (r_state == ST_ISSUE);
    assign oLcdData  = (r_state == ST_ISSUE) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_lcd_char_fifo.sv
// Scoreboard bench for lcd_char_fifo: expected LCD bytes queued at push time, checked at each handshake.
module tb_lcd_char_fifo;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       iWrite = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iLcdReady = 1'b1;
    logic       iClearOvf = 1'b0;
    logic       oReady;
    logic       oFull;
    logic       oEmpty;
    logic [3:0] oCount;
    logic       oLcdWrite;
    logic [7:0] oLcdData;
    logic       oOverflow;

`ifdef LCD_FIFO_OVF_STICKY_EN
    localparam int OVF_EXP = 1;
`else
    localparam int OVF_EXP = 0;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         lcd_busy = 4;
    bit         lcd_hold = 1'b0;
    bit         never_drop = 1'b0;

    lcd_char_fifo #(.DATA_W(8), .DEPTH_LOG2(3), .BUSY_WAIT(15)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .iWrite    (iWrite),
        .iData     (iData),
        .oReady    (oReady),
        .oFull     (oFull),
        .oEmpty    (oEmpty),
        .oCount    (oCount),
        .oLcdWrite (oLcdWrite),
        .oLcdData  (oLcdData),
        .iLcdReady (iLcdReady),
        .oOverflow (oOverflow),
        .iClearOvf (iClearOvf)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // LCD controller model and output monitor: compares every handshaken byte.
    initial begin : lcd_model
        int busy;
        bit hs;
        busy = 0;
        forever begin
            @(negedge Clock);
            hs = oLcdWrite && iLcdReady && !Reset;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL lcd_byte: got 0x%0h, expected no transfer", oLcdData);
                end else begin
                    chk("lcd_byte", oLcdData, exp_q.pop_front());
                end
            end
            @(posedge Clock);
            #1;
            if (hs && !never_drop) busy = lcd_busy;
            if (lcd_hold) begin
                iLcdReady = 1'b0;
            end else if (busy > 0) begin
                iLcdReady = 1'b0;
                busy--;
            end else begin
                iLcdReady = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit accept);
        iWrite = 1'b1;
        iData  = b;
        if (accept) exp_q.push_back(b);
        tick();
        iWrite = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int k;
        k = 0;
        while (!(oEmpty && exp_q.size() == 0) && k < budget) begin
            tick();
            k++;
        end
        chk(name, oEmpty, 1);
        chk({name, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic wait_issue(input string name, input int budget, output int k);
        k = 0;
        while (!oLcdWrite && k < budget) begin
            tick();
            k++;
        end
        chk(name, oLcdWrite, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int k;
        tick();
        tick();
        Reset = 1'b0;
        tick();
        chk("rst_count", oCount, 0);
        chk("rst_empty", oEmpty, 1);
        chk("rst_full", oFull, 0);
        chk("rst_ready", oReady, 1);
        chk("rst_lcdwrite", oLcdWrite, 0);
        chk("rst_lcddata", oLcdData, 0);
        chk("rst_ovf", oOverflow, 0);

        // Single byte: issue two edges after the push.
        lcd_busy = 4;
        push(8'h41, 1'b1);
        chk("t1_lcdwrite_edge1", oLcdWrite, 0);
        chk("t1_empty_edge1", oEmpty, 0);
        tick();
        chk("t1_lcdwrite_edge2", oLcdWrite, 1);
        chk("t1_lcddata_edge2", oLcdData, 8'h41);
        wait_empty("t1_drain", 40);

        // Fill while the controller is busy.
        lcd_hold = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i), 1'b1);
        chk("t2_count_full", oCount, 8);
        chk("t2_full", oFull, 1);
        chk("t2_ready", oReady, 0);

        // Push into a full FIFO is dropped.
        push(8'h99, 1'b0);
        chk("t3_ovf_set", oOverflow, OVF_EXP);
        chk("t3_count", oCount, 8);
        iClearOvf = 1'b1;
        tick();
        iClearOvf = 1'b0;
        chk("t3_ovf_clr", oOverflow, 0);
        lcd_hold = 1'b0;
        wait_empty("t2_drain", 200);

        // Push coinciding with pop keeps the count; 23 bytes wrap the pointers.
        lcd_busy = 1;
        lcd_hold = 1'b1;
        tick(); tick();
        push(8'h50, 1'b1);
        push(8'h51, 1'b1);
        push(8'h52, 1'b1);
        chk("t4_count3", oCount, 3);
        lcd_hold = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wait_issue("t4_issue", 20, k);
            chk("t4_count_pre", oCount, 3);
            push(8'h60 + 8'(i), 1'b1);
            chk("t4_count_post", oCount, 3);
        end
        wait_empty("t4_drain", 100);

        // Reset while issuing with five bytes queued.
        lcd_busy = 4;
        lcd_hold = 1'b1;
        tick(); tick();
        for (int i = 0; i < 5; i++) push(8'h80 + 8'(i), 1'b1);
        chk("t5_count5", oCount, 5);
        lcd_hold = 1'b0;
        wait_issue("t5_issue", 20, k);
        Reset = 1'b1;
        #1;
        chk("t5_lcdwrite", oLcdWrite, 0);
        chk("t5_count", oCount, 0);
        chk("t5_empty", oEmpty, 1);
        exp_q.delete();
        tick();
        Reset = 1'b0;
        tick();
        tick();
        chk("t5_idle", oLcdWrite, 0);

        // Controller never signals busy: timeout returns to IDLE.
        never_drop = 1'b1;
        push(8'h70, 1'b1);
        push(8'h71, 1'b1);
        wait_issue("t6_issue1", 20, k);
        tick();
        chk("t6_lcdwrite_after", oLcdWrite, 0);
        wait_issue("t6_issue2", 40, k);
        chk("t6_gap", k, 16);
        chk("t6_data2", oLcdData, 8'h71);
        wait_empty("t6_drain", 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
